// File: rtl/axi_frame_writer_pkg.sv
// axi_frame_writer_pkg: FSM encoding, fixed AXI attributes and burst geometry helpers
package axi_frame_writer_pkg;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_RESP  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [3:0] AXI_CACHE_VAL  = 4'b0000;
   localparam logic [2:0] AXI_PROT_VAL   = 3'b010;
   function automatic int burst_bytes(input int data_width, input int burst_len);
      return burst_len * data_width / 8;
   endfunction
   function automatic logic [2:0] axsize(input int data_width);
      return data_width == 128 ? 3'd4 : data_width == 64 ? 3'd3 : 3'd2;
   endfunction
endpackage

// File: rtl/axi_frame_ring_ctrl.sv
// axi_frame_ring_ctrl: frame-buffer ring bookkeeping (offset, write index, pending start)
// and the address of the next burst.
module axi_frame_ring_ctrl
   import axi_frame_writer_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int BURST_LEN = 64,
   parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = 32'h0100_0000,
   parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_STRIDE = 32'h0004_0000,
   parameter int FRAME_BYTES = 153600,
   parameter int NUM_FRAMES = 3
) (
   input  logic                      clk_100Mhz,
   input  logic                      rst,
   input  logic                      frame_start_i,
   input  logic                      apply_start_i,
   input  logic                      burst_done_i,
   output logic                      pending_o,
   output logic                      frame_full_o,
   output logic [AXI_ADDR_WIDTH-1:0] next_addr_o,
   output logic [1:0]                done_frame_idx_o,
   output logic                      frame_complete_o
);
   localparam logic [AXI_ADDR_WIDTH-1:0] BB = AXI_ADDR_WIDTH'(burst_bytes(AXI_DATA_WIDTH, BURST_LEN));
   localparam logic [AXI_ADDR_WIDTH-1:0] FB = AXI_ADDR_WIDTH'(FRAME_BYTES);
   localparam logic [1:0] LAST_IDX = 2'(NUM_FRAMES - 1);
   logic [AXI_ADDR_WIDTH-1:0] offset_q, offset_d, offset_inc;
   logic [1:0] wr_idx_q, wr_idx_d, done_q, done_d;
   logic pending_q, pending_d, fc_q, fc_d;
   always_comb begin
      offset_inc = offset_q + BB;
      offset_d   = apply_start_i ? '0 : burst_done_i ? offset_inc : offset_q;
      wr_idx_d   = !apply_start_i ? wr_idx_q : (wr_idx_q == LAST_IDX) ? 2'd0 : wr_idx_q + 2'd1;
      // a start arriving in the same cycle another is applied belongs to the next frame
      pending_d  = frame_start_i | (pending_q & ~apply_start_i);
      fc_d       = burst_done_i & (offset_inc == FB);
      done_d     = fc_d ? wr_idx_q : done_q;
   end
   always_ff @(posedge clk_100Mhz or posedge rst) begin
      if (rst) begin
         offset_q  <= '0;
         wr_idx_q  <= 2'd0;
         done_q    <= LAST_IDX;
         pending_q <= 1'b0;
         fc_q      <= 1'b0;
      end else begin
         offset_q  <= offset_d;
         wr_idx_q  <= wr_idx_d;
         done_q    <= done_d;
         pending_q <= pending_d;
         fc_q      <= fc_d;
      end
   end
   assign pending_o        = pending_q;
   assign frame_full_o     = offset_q == FB;
   assign next_addr_o      = FRAME_BASE_ADDR + AXI_ADDR_WIDTH'(wr_idx_q) * FRAME_STRIDE + offset_q;
   assign done_frame_idx_o = done_q;
   assign frame_complete_o = fc_q;
endmodule

// File: rtl/axi_frame_writer.sv
// axi_frame_writer: FWFT stream to AXI4 INCR-burst writer over a ring of frame buffers.
// Optional AXI_FRAME_WRITER_ERRCNT_EN adds err_count / last_err_addr for BRESP errors.
module axi_frame_writer
   import axi_frame_writer_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int BURST_LEN = 64,
   parameter int LEVEL_WIDTH = 10,
   parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = 32'h0100_0000,
   parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_STRIDE = 32'h0004_0000,
   parameter int FRAME_BYTES = 153600,
   parameter int NUM_FRAMES = 3
) (
   input  logic                        clk_100Mhz,
   input  logic                        rst,
   input  logic [AXI_DATA_WIDTH-1:0]   s_tdata,
   input  logic                        s_tvalid,
   output logic                        s_tready,
   input  logic [LEVEL_WIDTH-1:0]      s_level,
   input  logic                        frame_start,
   output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
   output logic                        AWVALID,
   input  logic                        AWREADY,
   output logic [7:0]                  AWLEN,
   output logic [2:0]                  AWSIZE,
   output logic [1:0]                  AWBURST,
   output logic [3:0]                  AWCACHE,
   output logic [2:0]                  AWPROT,
   output logic [AXI_DATA_WIDTH-1:0]   WDATA,
   output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
   output logic                        WVALID,
   input  logic                        WREADY,
   output logic                        WLAST,
   input  logic [1:0]                  BRESP,
   input  logic                        BVALID,
   output logic                        BREADY,
   output logic [1:0]                  done_frame_idx,
   output logic                        frame_complete,
   output logic                        overflow,
   output logic [2:0]                  state
`ifdef AXI_FRAME_WRITER_ERRCNT_EN
   ,
   output logic [15:0]                 err_count,
   output logic [AXI_ADDR_WIDTH-1:0]   last_err_addr
`endif
);
   localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
   logic [2:0] state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, next_addr;
   logic [7:0] cnt_q, cnt_d;
   logic overflow_q, overflow_d;
   logic pending, frame_full, apply_start, burst_done, w_hs, d_hs, beat_last, level_ok;
   axi_frame_ring_ctrl #(
      .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_DATA_WIDTH(AXI_DATA_WIDTH), .BURST_LEN(BURST_LEN),
      .FRAME_BASE_ADDR(FRAME_BASE_ADDR), .FRAME_STRIDE(FRAME_STRIDE),
      .FRAME_BYTES(FRAME_BYTES), .NUM_FRAMES(NUM_FRAMES)
   ) u_ring (
      .clk_100Mhz(clk_100Mhz), .rst(rst), .frame_start_i(frame_start),
      .apply_start_i(apply_start), .burst_done_i(burst_done), .pending_o(pending),
      .frame_full_o(frame_full), .next_addr_o(next_addr),
      .done_frame_idx_o(done_frame_idx), .frame_complete_o(frame_complete)
   );
   assign level_ok    = 32'(s_level) >= 32'(BURST_LEN);
   assign apply_start = (state_q == S_IDLE) & pending;
   assign burst_done  = (state_q == S_RESP) & BVALID;
   // zero-cycle pop: the FWFT head is presented on W and popped on the same handshake
   assign s_tready    = (state_q == S_DATA) ? WREADY & s_tvalid : (state_q == S_DRAIN);
   assign WVALID      = (state_q == S_DATA) & s_tvalid;
   assign w_hs        = WVALID & WREADY;
   assign d_hs        = (state_q == S_DRAIN) & s_tvalid;
   assign beat_last   = cnt_q == LAST_BEAT;
   assign WLAST       = beat_last & WVALID;
   always_comb begin
      state_d    = state_q;
      awaddr_d   = awaddr_q;
      overflow_d = overflow_q;
      cnt_d      = (w_hs | d_hs) ? (beat_last ? 8'd0 : cnt_q + 8'd1) : cnt_q;
      case (state_q)
         S_IDLE: if (!pending && level_ok) begin
            overflow_d = overflow_q | frame_full;
            awaddr_d   = frame_full ? awaddr_q : next_addr;
            state_d    = frame_full ? S_DRAIN : S_ADDR;
         end
         S_ADDR:  state_d = AWREADY ? S_DATA : S_ADDR;
         S_DATA:  state_d = (w_hs & beat_last) ? S_RESP : S_DATA;
         S_RESP:  state_d = BVALID ? S_IDLE : S_RESP;
         S_DRAIN: state_d = (d_hs & beat_last) ? S_IDLE : S_DRAIN;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk_100Mhz or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         awaddr_q   <= FRAME_BASE_ADDR;
         cnt_q      <= 8'd0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         awaddr_q   <= awaddr_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
      end
   end
   assign AWADDR   = awaddr_q;
   assign AWVALID  = state_q == S_ADDR;
   assign AWLEN    = LAST_BEAT;
   assign AWSIZE   = axsize(AXI_DATA_WIDTH);
   assign AWBURST  = AXI_BURST_INCR;
   assign AWCACHE  = AXI_CACHE_VAL;
   assign AWPROT   = AXI_PROT_VAL;
   assign WDATA    = s_tdata;
   assign WSTRB    = '1;
   assign BREADY   = state_q == S_RESP;
   assign overflow = overflow_q;
   assign state    = state_q;
`ifdef AXI_FRAME_WRITER_ERRCNT_EN
   logic [15:0] err_count_q, err_count_d;
   logic [AXI_ADDR_WIDTH-1:0] last_err_addr_q, last_err_addr_d;
   logic err_hs;
   assign err_hs = burst_done & (BRESP != 2'b00);
   always_comb begin
      err_count_d     = (err_hs && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
      last_err_addr_d = err_hs ? awaddr_q : last_err_addr_q;
   end
   always_ff @(posedge clk_100Mhz or posedge rst) begin
      if (rst) begin
         err_count_q     <= 16'd0;
         last_err_addr_q <= '0;
      end else begin
         err_count_q     <= err_count_d;
         last_err_addr_q <= last_err_addr_d;
      end
   end
   assign err_count     = err_count_q;
   assign last_err_addr = last_err_addr_q;
`else
   logic unused_bresp;
   assign unused_bresp = ^BRESP;
`endif
endmodule

// File: tb/tb_axi_frame_writer.sv
// tb_axi_frame_writer: scenario table plus randomized AXI/stream stalls, checked against
// a frame/offset reference model and a data scoreboard.
module tb_axi_frame_writer;
   localparam int FB = 4096;
   localparam int BL = 64;
   localparam int BB = 512;
   localparam logic [31:0] BASE = 32'h0100_0000;
   localparam logic [31:0] STRIDE = 32'h0004_0000;
   logic clk_100Mhz = 1'b0;
   logic rst = 1'b1;
   logic [63:0] s_tdata = '0;
   logic s_tvalid = 1'b0, s_tready;
   logic [9:0] s_level = '0;
   logic frame_start = 1'b0;
   logic [31:0] AWADDR;
   logic AWVALID, AWREADY = 1'b0;
   logic [7:0] AWLEN;
   logic [2:0] AWSIZE;
   logic [1:0] AWBURST;
   logic [3:0] AWCACHE;
   logic [2:0] AWPROT;
   logic [63:0] WDATA;
   logic [7:0] WSTRB;
   logic WVALID, WREADY = 1'b0, WLAST;
   logic [1:0] BRESP = 2'b00;
   logic BVALID = 1'b0, BREADY;
   logic [1:0] done_frame_idx;
   logic frame_complete, overflow;
   logic [2:0] state;
`ifdef AXI_FRAME_WRITER_ERRCNT_EN
   logic [15:0] err_count;
   logic [31:0] last_err_addr;
`endif
   axi_frame_writer #(.FRAME_BYTES(FB)) dut (
      .clk_100Mhz(clk_100Mhz), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tready(s_tready), .s_level(s_level), .frame_start(frame_start),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
      .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY), .done_frame_idx(done_frame_idx),
      .frame_complete(frame_complete), .overflow(overflow), .state(state)
`ifdef AXI_FRAME_WRITER_ERRCNT_EN
      , .err_count(err_count), .last_err_addr(last_err_addr)
`endif
   );
   always #5 clk_100Mhz = ~clk_100Mhz;

   typedef struct {
      int full; int extra; bit mid; int stall; int err_burst;
      logic [31:0] last_aw; int aw; int fc; logic [1:0] done; logic ovf; int drained;
      logic [15:0] errs; logic [31:0] err_addr;
   } row_t;
   row_t rows[5];

   int checks = 0, fails = 0;
   logic [63:0] src_q[$], exp_q[$];
   int mf, mo, beat, aw_cnt, fc_cnt, drained, b_cnt, stall, err_burst;
   bit in_flight, b_owed, defer, fc_exp, fs_req;
   logic [1:0] exp_done;
   logic [31:0] last_aw;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      src_q.delete(); exp_q.delete();
      mf = 0; mo = 0; beat = 0; aw_cnt = 0; fc_cnt = 0; drained = 0; b_cnt = 0;
      in_flight = 0; b_owed = 0; defer = 0; fc_exp = 0; fs_req = 0; exp_done = 2'd2; last_aw = '0;
   endtask

   task automatic advance_frame();
      mf = (mf + 1) % 3;
      mo = 0;
   endtask

   // drive at the falling edge, observe 1 time unit later what the next rising edge will commit
   task automatic cycle();
      logic [63:0] w;
      @(negedge clk_100Mhz);
      frame_start = fs_req; fs_req = 0;
      s_tvalid = src_q.size() > 0 && $urandom_range(99) >= stall;
      s_tdata  = src_q.size() > 0 ? src_q[0] : 64'd0;
      s_level  = 10'(src_q.size());
      AWREADY  = $urandom_range(99) >= stall;
      WREADY   = $urandom_range(99) >= stall;
      BVALID   = b_owed && $urandom_range(99) >= stall;
      BRESP    = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (frame_complete || fc_exp) begin
         check("frame_complete", frame_complete, fc_exp);
         check("done_frame_idx_at_complete", done_frame_idx, exp_done);
      end
      fc_cnt += int'(frame_complete);
      fc_exp = 0;
      if (frame_start) begin
         if (in_flight) defer = 1;
         else advance_frame();
      end
      if (AWVALID && AWREADY) begin
         check("awaddr", AWADDR, BASE + 32'(mf) * STRIDE + 32'(mo));
         last_aw = AWADDR; aw_cnt++; in_flight = 1; beat = 0;
      end
      if (WVALID && WREADY) begin
         w = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
         check("wdata", WDATA, w);
         check("wlast", WLAST, beat == BL - 1);
         beat++;
         if (beat == BL) b_owed = 1;
      end
      if (s_tvalid && s_tready) begin
         if (src_q.size() > 0) void'(src_q.pop_front());
         if (!WVALID) drained++;
      end
      if (BVALID && BREADY) begin
         b_owed = 0; in_flight = 0; b_cnt++;
         mo += BB;
         if (mo == FB) begin fc_exp = 1; exp_done = 2'(mf); end
         if (defer) begin defer = 0; advance_frame(); end
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_state"}, state, 3'd0);
      check({tag, "_awvalid"}, AWVALID, 1'b0);
      check({tag, "_wvalid"}, WVALID, 1'b0);
      check({tag, "_bready"}, BREADY, 1'b0);
      check({tag, "_tready"}, s_tready, 1'b0);
      check({tag, "_awaddr"}, AWADDR, BASE);
      check({tag, "_fc"}, frame_complete, 1'b0);
      check({tag, "_ovf"}, overflow, 1'b0);
      check({tag, "_done"}, done_frame_idx, 2'd2);
      check({tag, "_axi_const"}, {AWLEN, AWSIZE, AWBURST, AWCACHE, AWPROT, WSTRB},
            {8'd63, 3'd3, 2'b01, 4'b0000, 3'b010, 8'hFF});
`ifdef AXI_FRAME_WRITER_ERRCNT_EN
      check({tag, "_err_count"}, err_count, 16'd0);
      check({tag, "_last_err_addr"}, last_err_addr, 32'd0);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk_100Mhz);
      rst = 1;
      model_clear();
      repeat (2) cycle();
      check_reset("reset");
      @(negedge clk_100Mhz);
      rst = 0;
   endtask

   task automatic run_burst(input bit mid);
      int n = 0, pulses = 0;
      bit to_w = (mo != FB);
      logic [63:0] w;
      for (int i = 0; i < BL; i++) begin
         w = {$urandom, $urandom};
         src_q.push_back(w);
         if (to_w) exp_q.push_back(w);
      end
      do begin
         if (mid && pulses < 2 && in_flight && beat >= 10 * (pulses + 1)) begin
            fs_req = 1; pulses++;
         end
         cycle(); n++;
      end while ((src_q.size() > 0 || in_flight) && n < 3000);
      if (n >= 3000) begin
         checks++; fails++;
         $display("FAIL burst_timeout: %0d words left, in_flight=%0d", src_q.size(), in_flight);
      end
   endtask

   initial begin
      int n;
      rows[0] = '{0, 2, 0, 0, 1, 32'h0100_0200, 2, 0, 2'd2, 1'b0, 0, 16'd1, 32'h0100_0200};
      rows[1] = '{1, 1, 0, 40, -1, 32'h0104_0000, 9, 1, 2'd0, 1'b0, 0, 16'd0, 32'd0};
      rows[2] = '{3, 1, 0, 20, -1, 32'h0100_0000, 25, 3, 2'd2, 1'b0, 0, 16'd0, 32'd0};
      rows[3] = '{0, 3, 1, 0, -1, 32'h0104_0200, 3, 0, 2'd2, 1'b0, 0, 16'd0, 32'd0};
      rows[4] = '{0, 9, 0, 30, -1, 32'h0100_0E00, 8, 1, 2'd0, 1'b1, 64, 16'd0, 32'd0};
      for (int r = 0; r < 5; r++) begin
         stall = rows[r].stall; err_burst = rows[r].err_burst;
         do_reset();
         stall = rows[r].stall; err_burst = rows[r].err_burst;
         for (int f = 0; f < rows[r].full; f++) begin
            for (int b = 0; b < FB / BB; b++) run_burst(0);
            fs_req = 1;
            cycle();
         end
         for (int b = 0; b < rows[r].extra; b++) run_burst(rows[r].mid && b == 0);
         repeat (4) cycle();
         check($sformatf("row%0d_last_aw", r), last_aw, rows[r].last_aw);
         check($sformatf("row%0d_aw_count", r), aw_cnt, rows[r].aw);
         check($sformatf("row%0d_fc_count", r), fc_cnt, rows[r].fc);
         check($sformatf("row%0d_done_idx", r), done_frame_idx, rows[r].done);
         check($sformatf("row%0d_overflow", r), overflow, rows[r].ovf);
         check($sformatf("row%0d_drained", r), drained, rows[r].drained);
`ifdef AXI_FRAME_WRITER_ERRCNT_EN
         check($sformatf("row%0d_err_count", r), err_count, rows[r].errs);
         check($sformatf("row%0d_last_err_addr", r), last_err_addr, rows[r].err_addr);
`endif
      end
      // error on the first burst, then reset in the middle of the second burst's data phase
      stall = 0; err_burst = -1;
      do_reset();
      err_burst = 0;
      run_burst(0);
`ifdef AXI_FRAME_WRITER_ERRCNT_EN
      check("err_first_burst_count", err_count, 16'd1);
      check("err_first_burst_addr", last_err_addr, BASE);
`endif
      for (int i = 0; i < BL; i++) begin
         src_q.push_back({$urandom, $urandom});
         exp_q.push_back(src_q[src_q.size() - 1]);
      end
      n = 0;
      while (!(aw_cnt == 2 && beat >= 5) && n < 500) begin cycle(); n++; end
      if (n >= 500) begin
         checks++; fails++;
         $display("FAIL mid_data_wait_timeout: aw_cnt=%0d beat=%0d", aw_cnt, beat);
      end
      check("state_before_reset", state, 3'd2);
      @(negedge clk_100Mhz);
      rst = 1;
      #1;
      check_reset("mid_data_reset");
      check("mid_data_reset_wlast", WLAST, 1'b0);
      model_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
